// File: rtl/atomrvcore_ifu_if.sv
// Fetch-unit bundle: decode-side redirect/handshake plus instruction-memory port.
// master is the IFU itself; slave is the decode/memory environment.
interface atomrvcore_ifu_if #(
    parameter int DATAWIDTH = 32
);
    logic                 IR_EN_i;
    logic                 PCrst_i;
    logic                 BE_i;
    logic                 JALRE_i;
    logic                 UJE_i;
    logic [DATAWIDTH-1:0] immed_i;
    logic [DATAWIDTH-1:0] operand_A_i;
    logic [DATAWIDTH-1:0] branch_pc_i;
    logic                 stall_i;
    logic                 imem_req_o;
    logic [DATAWIDTH-1:0] imem_addr_o;
    logic                 imem_rvalid_i;
    logic [DATAWIDTH-1:0] imem_rdata_i;
    logic [DATAWIDTH-1:0] instr_o;
    logic [DATAWIDTH-1:0] pc_o;
    logic                 instr_valid_o;
    logic                 misaligned_o;

    modport master (
        input  IR_EN_i, PCrst_i, BE_i, JALRE_i, UJE_i, immed_i, operand_A_i,
               branch_pc_i, stall_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, misaligned_o
    );

    modport slave (
        output IR_EN_i, PCrst_i, BE_i, JALRE_i, UJE_i, immed_i, operand_A_i,
               branch_pc_i, stall_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, misaligned_o
    );
endinterface

// File: rtl/atomrvcore_ifu.sv
// Instruction fetch unit: one outstanding imem read, redirect/flush handling,
// and a single output register held under decode back-pressure.
module atomrvcore_ifu #(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
    input logic              clk_i,
    input logic              rst_i,
    atomrvcore_ifu_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] pc_q, pc_d;
    logic                 flush_q, flush_d;
    logic [DATAWIDTH-1:0] instr_q, instr_d;
    logic [DATAWIDTH-1:0] pco_q, pco_d;
    logic                 valid_q, valid_d;
    logic                 mis_q, mis_d;

    logic                 soft_rst;
    logic                 redirect;
    logic                 fetch_ok;
    logic [DATAWIDTH-1:0] jalr_sum;
    logic [DATAWIDTH-1:0] target;

    assign soft_rst = ~bus.PCrst_i;
    assign redirect = soft_rst | bus.JALRE_i | bus.UJE_i | bus.BE_i;
    assign fetch_ok = bus.IR_EN_i & bus.PCrst_i;
    assign jalr_sum = bus.operand_A_i + bus.immed_i;

    // JAL and taken branch share the PC-relative target; only JALR differs.
    always_comb begin
        target = bus.branch_pc_i + (bus.immed_i << 1);
        if (soft_rst) begin
            target = RESET_PC;
        end else if (bus.JALRE_i) begin
            target = {jalr_sum[DATAWIDTH-1:1], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        valid_d = valid_q & bus.stall_i;
        mis_d   = 1'b0;

        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
            mis_d   = target[1];
        end

        unique case (state_q)
            IDLE: begin
                state_d = fetch_ok ? REQ : IDLE;
            end
            REQ: begin
                state_d = WAIT;
                flush_d = redirect;
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    // A stale or redirect-coincident response is dropped here.
                    if (flush_q || redirect) begin
                        flush_d = 1'b0;
                        state_d = fetch_ok ? REQ : IDLE;
                    end else begin
                        instr_d = bus.imem_rdata_i;
                        pco_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + DATAWIDTH'(4);
                        if (bus.stall_i) begin
                            state_d = HOLD;
                        end else begin
                            state_d = bus.IR_EN_i ? REQ : IDLE;
                        end
                    end
                end else if (redirect) begin
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = fetch_ok ? REQ : IDLE;
                end else if (!bus.stall_i) begin
                    state_d = bus.IR_EN_i ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            instr_q <= '0;
            pco_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.imem_req_o    = (state_q == REQ);
    assign bus.imem_addr_o   = (state_q == REQ) ? {pc_q[DATAWIDTH-1:2], 2'b00} : '0;
    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pco_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.misaligned_o  = mis_q;
endmodule

// File: tb/tb_atomrvcore_ifu.sv
// Bench for atomrvcore_ifu: directed scenarios followed by random traffic,
// checked against a transaction-level fetch model and a latency-variable memory.
module tb_atomrvcore_ifu;
    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atomrvcore_ifu_if #(.DATAWIDTH(W)) bus ();
    atomrvcore_ifu #(.DATAWIDTH(W), .RESET_PC(RPC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // memory side
    int          lat = 1;
    bit          mem_const = 1'b1;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    // fetch model: next fetch pc, in-flight request, undelivered captures
    logic [31:0] np = RPC;
    bit          inf = 1'b0;
    bit          inf_fl = 1'b0;
    logic [31:0] inf_pc = '0;
    logic [31:0] outq[$];
    bit          exp_mis = 1'b0;
    int          n_deliv = 0;

    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_instr, s_pco;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        return mem_const ? 32'h0000_0013 : ((al ^ 32'h5A5A_0F0F) + 32'h0000_1001);
    endfunction

    function automatic logic [31:0] model_target();
        if (!bus.PCrst_i) return RPC;
        if (bus.JALRE_i)  return (bus.operand_A_i + bus.immed_i) & 32'hFFFF_FFFE;
        return bus.branch_pc_i + 2 * bus.immed_i;
    endfunction

    task automatic step();
        logic [31:0] p;
        logic [31:0] tgt;
        @(negedge clk);
        s_req   = bus.imem_req_o;
        s_addr  = bus.imem_addr_o;
        s_valid = bus.instr_valid_o;
        s_instr = bus.instr_o;
        s_pco   = bus.pc_o;
        s_mis   = bus.misaligned_o;
        if (rst) begin
            check("rst_req", {31'd0, s_req}, 32'd0);
            check("rst_addr", s_addr, 32'd0);
            check("rst_valid", {31'd0, s_valid}, 32'd0);
            check("rst_instr", s_instr, 32'd0);
            check("rst_pc_o", s_pco, 32'd0);
            check("rst_mis", {31'd0, s_mis}, 32'd0);
            np = RPC; inf = 1'b0; inf_fl = 1'b0; exp_mis = 1'b0;
            outq.delete();
        end else begin
            check("valid", {31'd0, s_valid}, {31'd0, outq.size() != 0});
            check("mis", {31'd0, s_mis}, {31'd0, exp_mis});
            if (s_valid && !bus.stall_i && outq.size() != 0) begin
                p = outq.pop_front();
                check("pc_o", s_pco, p);
                check("instr", s_instr, memf(p));
                n_deliv++;
            end
            if (s_req) begin
                check("addr", s_addr, {np[31:2], 2'b00});
                check("outstanding", {31'd0, m_busy}, 32'd0);
                inf = 1'b1; inf_pc = np; inf_fl = 1'b0;
            end
            if (!bus.PCrst_i || bus.JALRE_i || bus.UJE_i || bus.BE_i) begin
                tgt = model_target();
                np = tgt;
                exp_mis = tgt[1];
                outq.delete();
                if (inf) inf_fl = 1'b1;
                if (bus.imem_rvalid_i) begin inf = 1'b0; inf_fl = 1'b0; end
            end else begin
                exp_mis = 1'b0;
                if (bus.imem_rvalid_i && inf) begin
                    if (!inf_fl) begin
                        outq.push_back(inf_pc);
                        np = inf_pc + 32'd4;
                    end
                    inf = 1'b0; inf_fl = 1'b0;
                end
            end
        end
        if (s_req) begin
            m_busy = 1'b1; m_cnt = lat; m_addr = s_addr;
        end
        @(posedge clk);
        #1;
        bus.imem_rvalid_i = 1'b0;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = memf(m_addr);
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_req) break;
        end
        check(tag, {31'd0, s_req}, 32'd1);
    endtask

    initial begin
        bus.IR_EN_i = 1'b0; bus.PCrst_i = 1'b1; bus.BE_i = 1'b0; bus.JALRE_i = 1'b0;
        bus.UJE_i = 1'b0; bus.immed_i = '0; bus.operand_A_i = '0; bus.branch_pc_i = '0;
        bus.stall_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // sequential fetch with single-cycle memory
        bus.IR_EN_i = 1'b1;
        wait_req("seq_req0");  check("seq_addr0", s_addr, 32'h0);
        wait_req("seq_req4");  check("seq_addr4", s_addr, 32'h4);
        wait_req("seq_req8");  check("seq_addr8", s_addr, 32'h8);

        // back-pressure on the capture of pc 8
        bus.stall_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_req", {31'd0, s_req}, 32'd0);
            check("hold_pc", s_pco, 32'h8);
            check("hold_valid", {31'd0, s_valid}, 32'd1);
        end
        bus.stall_i = 1'b0;
        step();
        check("deliv3", n_deliv, 32'd3);

        // taken branch while waiting on a slow response
        lat = 3;
        wait_req("br_req12");  check("br_addr12", s_addr, 32'hC);
        bus.BE_i = 1'b1; bus.branch_pc_i = 32'h8; bus.immed_i = 32'hFFFF_FFFC;
        step();
        bus.BE_i = 1'b0;
        wait_req("br_tgt");    check("br_addr", s_addr, 32'h0);

        // JALR to a halfword-aligned target
        bus.JALRE_i = 1'b1; bus.operand_A_i = 32'h103; bus.immed_i = 32'h0;
        step();
        bus.JALRE_i = 1'b0;
        step();  check("mis_pulse", {31'd0, s_mis}, 32'd1);
        step();  check("mis_clear", {31'd0, s_mis}, 32'd0);
        wait_req("jalr_req");  check("jalr_addr", s_addr, 32'h100);

        // soft reset beats a coincident JALR
        bus.PCrst_i = 1'b0; bus.JALRE_i = 1'b1; bus.operand_A_i = 32'h200;
        step();
        bus.JALRE_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("pcrst_noreq", {31'd0, s_req}, 32'd0);
        end
        bus.PCrst_i = 1'b1;
        lat = 1;
        wait_req("pcrst_req"); check("pcrst_addr", s_addr, RPC);

        // sequential wrap at the top of the address space
        bus.JALRE_i = 1'b1; bus.operand_A_i = 32'hFFFF_FFFC; bus.immed_i = 32'h0;
        step();
        bus.JALRE_i = 1'b0;
        wait_req("top_req");   check("top_addr", s_addr, 32'hFFFF_FFFC);
        wait_req("wrap_req");  check("wrap_addr", s_addr, 32'h0);

        // hard reset while a response is still in flight
        lat = 3;
        wait_req("rst_wait_req");
        bus.IR_EN_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("stale_valid", {31'd0, s_valid}, 32'd0);
            check("stale_req", {31'd0, s_req}, 32'd0);
        end

        // random traffic
        mem_const = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            bus.IR_EN_i = ($urandom_range(0, 9) != 0);
            bus.PCrst_i = ($urandom_range(0, 59) != 0);
            r = $urandom_range(0, 29);
            bus.JALRE_i     = (r == 0) || (r == 3);
            bus.UJE_i       = (r == 1) || (r == 3);
            bus.BE_i        = (r == 2) || (r == 3);
            bus.operand_A_i = $urandom;
            bus.branch_pc_i = $urandom;
            bus.immed_i     = $urandom;
            lat = $urandom_range(1, 4);
            if (bus.instr_valid_o && (m_busy || bus.imem_rvalid_i || bus.imem_req_o))
                bus.stall_i = 1'b0;
            else
                bus.stall_i = ($urandom_range(0, 2) == 0);
            step();
        end
        check("progress", {31'd0, n_deliv > 150}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
